// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types, RAM handshake states and memory arbiter states
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} arbstate_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data access, data first with a starvation cap
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_MAX = 15
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);
  localparam logic [2:0] SMAX = 3'(STARVE_MAX);
  localparam logic [3:0] TMAX = 4'(TIMEOUT_MAX);
  arbstate_t state, next_state;
  logic [2:0] starv;
  logic [3:0] tmo;
  logic dg, ig, dreq, req, done, fail, fin;
  assign dg   = state == DGRANT;
  assign ig   = state == IGRANT;
  assign dreq = dREN | dWEN;
  assign req  = dg ? dreq : ig & iREN;
  assign done = req & (ramstate == ACCESS);
  // a clean ACCESS wins over a timeout landing in the same cycle
  assign fail = req & (ramstate != ACCESS) & ((ramstate == ERROR) | (tmo == TMAX));
  assign fin  = done | fail;
  always_comb begin
    next_state = state == IDLE ? ((dreq && starv < SMAX) ? DGRANT : iREN ? IGRANT : IDLE)
                               : (req && !fin) ? state : IDLE;
  end
  assign ramREN   = dg ? dREN & ~dWEN : ig & iREN;
  assign ramWEN   = dg & dWEN;
  assign ramaddr  = dg ? daddr : ig ? iaddr : '0;
  assign ramstore = dg ? dstore : '0;
  assign iwait    = iREN & ~(ig & fin);
  assign dwait    = dreq & ~(dg & fin);
  assign iload    = (ig & done) ? ramload : '0;
  assign dload    = (dg & done) ? ramload : '0;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      starv <= '0;
      tmo   <= '0;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      starv <= (dg & done & iREN) ? starv + {2'b0, ~&starv}
             : ((ig & done) | (state == IDLE & ~iREN)) ? '0 : starv;
      tmo   <= (state != IDLE && next_state != IDLE) ? tmo + 4'd1 : '0;
      err   <= err | fail;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of fetch, data priority, starvation, timeout, abort and reset
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  logic CLK = 1'b0, nRST = 1'b0;
  logic iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  word_t iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  word_t iload, dload, ramaddr, ramstore;
  logic iwait, dwait, ramREN, ramWEN, err;
  ramstate_t ramstate = FREE;
  int n_cmp = 0, n_bad = 0;
  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    iREN = 1'b1;
    #3;
    chk("rst_iwait", iwait, 1);
    chk("rst_ramren", ramREN, 0);
    chk("rst_iload", iload, 0);
    chk("rst_err", err, 0);
    iREN = 1'b0;
    cyc();
    nRST = 1'b1;
    // fetch only
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
    #1;
    chk("f_idle_iwait", iwait, 1);
    chk("f_idle_ramren", ramREN, 0);
    cyc();
    ramstate = ACCESS; ramload = 32'h8C22_0004;
    #1;
    chk("f_ramren", ramREN, 1);
    chk("f_ramaddr", ramaddr, 32'h40);
    chk("f_iwait", iwait, 0);
    chk("f_iload", iload, 32'h8C22_0004);
    cyc();
    chk("f_after_iwait", iwait, 1);
    chk("f_after_iload", iload, 0);
    iREN = 1'b0;
    #1;
    chk("f_noreq_iwait", iwait, 0);
    // simultaneous: data first, then fetch after one idle cycle
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; iREN = 1'b1; iaddr = 32'h44;
    ramload = 32'h1234_5678;
    #1;
    chk("s_idle_dwait", dwait, 1);
    chk("s_idle_ramwen", ramWEN, 0);
    cyc();
    chk("s_d_ramwen", ramWEN, 1);
    chk("s_d_ramren", ramREN, 0);
    chk("s_d_ramaddr", ramaddr, 32'h100);
    chk("s_d_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("s_d_dwait", dwait, 0);
    chk("s_d_iwait", iwait, 1);
    chk("s_d_dload", dload, 32'h1234_5678);
    chk("s_d_iload", iload, 0);
    cyc();
    dWEN = 1'b0;
    #1;
    chk("s_gap_ramwen", ramWEN, 0);
    chk("s_gap_ramaddr", ramaddr, 0);
    chk("s_gap_iwait", iwait, 1);
    cyc();
    chk("s_i_ramren", ramREN, 1);
    chk("s_i_ramaddr", ramaddr, 32'h44);
    chk("s_i_ramstore", ramstore, 0);
    chk("s_i_iwait", iwait, 0);
    chk("s_i_iload", iload, 32'h1234_5678);
    cyc();
    iREN = 1'b0;
    // starvation: four data grants, one fetch, then data again
    dREN = 1'b1; iREN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("st_iwait_%0d", k), iwait, (k == 4) ? 1'b0 : 1'b1);
      chk($sformatf("st_dwait_%0d", k), dwait, (k == 4) ? 1'b1 : 1'b0);
      cyc();
    end
    dREN = 1'b0; iREN = 1'b0;
    cyc();
    // abort on the second grant cycle
    dREN = 1'b1; daddr = 32'h200; ramstate = BUSY;
    cyc();
    chk("a_ramren", ramREN, 1);
    chk("a_dwait", dwait, 1);
    cyc();
    dREN = 1'b0;
    #1;
    chk("a_drop_ramren", ramREN, 0);
    chk("a_drop_dwait", dwait, 0);
    chk("a_drop_dload", dload, 0);
    cyc();
    chk("a_idle_ramaddr", ramaddr, 0);
    chk("a_idle_tmo", dut.tmo, 0);
    chk("a_idle_starv", dut.starv, 0);
    chk("a_idle_err", err, 0);
    // timeout: BUSY for the whole grant
    dREN = 1'b1; daddr = 32'h300; ramload = 32'hAAAA_5555;
    cyc();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("t_dwait_%0d", i), dwait, 1);
      cyc();
    end
    chk("t_end_dwait", dwait, 0);
    chk("t_end_dload", dload, 0);
    chk("t_end_err_pre", err, 0);
    cyc();
    chk("t_err", err, 1);
    chk("t_idle_dwait", dwait, 1);
    dREN = 1'b0;
    repeat (3) cyc();
    chk("t_err_sticky", err, 1);
    // reset in the middle of a fetch grant
    iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY;
    cyc();
    chk("r_grant_ramren", ramREN, 1);
    nRST = 1'b0;
    #1;
    chk("r_ramren", ramREN, 0);
    chk("r_ramaddr", ramaddr, 0);
    chk("r_iwait", iwait, 1);
    chk("r_iload", iload, 0);
    chk("r_err", err, 0);
    cyc();
    nRST = 1'b1;
    #1;
    chk("r_rel_ramren", ramREN, 0);
    cyc();
    chk("r_regrant_ramren", ramREN, 1);
    chk("r_regrant_ramaddr", ramaddr, 32'h80);
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    #1;
    chk("r_done_iwait", iwait, 0);
    chk("r_done_iload", iload, 32'h0BAD_F00D);
    cyc();
    iREN = 1'b0;
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
